// File: rtl/sc_fir_engine.sv
// sc_fir_engine: stochastic-computing FIR engine.
// A run lasts 2^N cycles. Each cycle the tap-select random number r_s picks the
// first tap whose cumulative coefficient threshold exceeds it. That tap's sample
// is compared against r_y, the result is XOR-ed with the tap's sign bit, and the
// resulting bit is accumulated. The count of ones is presented on out.
// Optional build macro SC_INTERNAL_RNG_EN: removes the r_y/r_s ports and
// generates both random numbers from internal Fibonacci LFSRs (N = 8..16).

module sc_fir_engine #(
  parameter int unsigned     N         = 12,
  parameter int unsigned     TAPS      = 19,
  parameter logic [TAPS-1:0] SIGN_MASK = 19'h198CC,
  parameter logic [N-1:0]    SEED_Y    = 'h001,
  parameter logic [N-1:0]    SEED_S    = 'h5A5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [TAPS*(N+1)-1:0] in_flat,
  input  logic [TAPS*(N+1)-1:0] cum_flat,
`ifndef SC_INTERNAL_RNG_EN
  input  logic [N-1:0]          r_y,
  input  logic [N-1:0]          r_s,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [N:0]            out
);

  localparam int unsigned W = N + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [TAPS*W-1:0] in_q, cum_q;
  logic [N-1:0]      cnt_q;
  logic [W-1:0]      acc_q, out_q;
  logic [N-1:0]      ry, rs;
  logic              sample_bit, tap_found, last_cycle, accept;

  assign accept     = (state_q == StIdle) && start;
  assign last_cycle = (cnt_q == '1);

`ifdef SC_INTERNAL_RNG_EN
  // Feedback tap masks (bit t-1 set for tap t) of maximal-length polynomials.
  function automatic logic [15:0] tap_mask(input int unsigned n);
    logic [15:0] m;
    case (n)
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  localparam logic [15:0]  TapMaskFull = tap_mask(N);
  localparam logic [N-1:0] TapMask     = TapMaskFull[N-1:0];

  logic [N-1:0] lfsr_y_q, lfsr_s_q;

  // LFSRs: reseeded on reset and accepted start, advanced only while running.
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      lfsr_y_q <= SEED_Y;
      lfsr_s_q <= SEED_S;
    end else if (state_q == StRun) begin
      lfsr_y_q <= {lfsr_y_q[N-2:0], ^(lfsr_y_q & TapMask)};
      lfsr_s_q <= {lfsr_s_q[N-2:0], ^(lfsr_s_q & TapMask)};
    end
  end

  assign ry = lfsr_y_q;
  assign rs = lfsr_s_q;
`else
  assign ry = r_y;
  assign rs = r_s;
`endif

  // Tap selection: first tap whose threshold exceeds r_s; no match gives a zero bit.
  always_comb begin
    sample_bit = 1'b0;
    tap_found  = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      if (!tap_found && ({1'b0, rs} < cum_q[k*W +: W])) begin
        tap_found  = 1'b1;
        sample_bit = (in_q[k*W +: W] > {1'b0, ry}) ^ SIGN_MASK[k];
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_cycle) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // Datapath: capture operands on start, accumulate while running, publish at the end.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_q  <= '0;
      cum_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      out_q <= '0;
    end else if (accept) begin
      in_q  <= in_flat;
      cum_q <= cum_flat;
      cnt_q <= '0;
      acc_q <= '0;
    end else if (state_q == StRun) begin
      cnt_q <= cnt_q + N'(1);
      acc_q <= acc_q + W'(sample_bit);
      // The last cycle's bit goes straight into out alongside the accumulator.
      if (last_cycle) begin
        out_q <= acc_q + W'(sample_bit);
      end
    end
  end

  assign out = out_q;

endmodule
